// File: rtl/instr_encoder.sv
// instr_encoder: program loader that encodes symbolic MIPS instructions
// (add, addu, sub, and, addi, lw, sw, beq, j) into 32-bit words and writes
// them into instruction memory at sequential word addresses.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, finish       1-cycle pulses opening (IDLE) / closing (LOAD) a session
//   in_valid, in_ready  symbolic instruction handshake
//   in_mnem             0 add,1 addu,2 sub,3 and,4 addi,5 lw,6 sw,7 beq,8 j
//   in_rs/in_rt/in_rd   register fields; in_imm immediate; in_adr jump target
//   imem_we/addr/wdata  instruction-memory write port (one cycle after accept)
//   busy, done, err     LOAD indicator, session-close pulse, sticky illegal flag
//   count               words written in the current/last session
module instr_encoder #(
  parameter int unsigned IMEM_AW   = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               finish,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_mnem,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [15:0]        in_imm,
  input  logic [25:0]        in_adr,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IMEM_AW:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

  localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);
  // Number of words that fit between BASE_ADDR and the top of memory.
  localparam logic [IMEM_AW:0]   CAP  = (IMEM_AW+1)'((1 << IMEM_AW) - BASE_ADDR);

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;
  logic [IMEM_AW:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [31:0]        word;
  logic               legal;
  logic               xfer;

  // Combinational encoding of the presented instruction.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (in_mnem)
      4'd0:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h20};
      4'd1:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h21};
      4'd2:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h22};
      4'd3:    word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h24};
      4'd4:    word = {6'h08, in_rs, in_rt, in_imm};
      4'd5:    word = {6'h23, in_rs, in_rt, in_imm};
      4'd6:    word = {6'h2B, in_rs, in_rt, in_imm};
      4'd7:    word = {6'h04, in_rs, in_rt, in_imm};
      4'd8:    word = {6'h02, in_adr};
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = (state_q == S_LOAD) && (count_q < CAP);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = BASE;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // An illegal mnemonic still completes the handshake; it only flags err.
        if (xfer) begin
          if (legal) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (finish) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (IMEM_AW=2, BASE_ADDR=0: capacity 4 words).
module tb_instr_encoder;

  localparam int unsigned AW  = 2;
  localparam int unsigned CAP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, finish, in_valid, in_ready;
  logic [3:0]    in_mnem;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [15:0]   in_imm;
  logic [25:0]   in_adr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, err;
  logic [AW:0]   count;

  instr_encoder #(.IMEM_AW(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_adr(in_adr),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  // Reference model: session state kept as plain integers.
  int unsigned m_state = 0;  // 0 idle, 1 load, 2 done
  int unsigned m_ptr   = 0;
  int unsigned m_cnt   = 0;
  bit          m_err   = 0;

  int unsigned OPC[9] = '{0, 0, 0, 0, 8, 35, 43, 4, 2};
  int unsigned FN[4]  = '{32, 33, 34, 36};

  function automatic logic [31:0] ref_enc(int unsigned m, int unsigned rs, int unsigned rt,
                                          int unsigned rd, int unsigned imm, int unsigned adr);
    int unsigned w;
    if (m < 4)      w = (rs << 21) + (rt << 16) + (rd << 11) + FN[m];
    else if (m < 8) w = (OPC[m] << 26) + (rs << 21) + (rt << 16) + imm;
    else            w = (2 << 26) + adr;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expectation in the cycle it is due.
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      chk("imem_we", {31'b0, imem_we}, 32'd1);
      chk("imem_addr", {30'b0, imem_addr}, sbq[0].addr);
      chk("imem_wdata", imem_wdata, sbq[0].data);
      void'(sbq.pop_front());
    end else if (imem_we === 1'b1) begin
      chk("unexpected_write", {30'b0, imem_addr}, 32'hFFFF_FFFF);
    end
  end

  // One clock of stimulus: drive, check status against the model, advance model.
  task automatic tick(input bit v, input bit st, input bit fin, input int unsigned m,
                      input int unsigned rs, input int unsigned rt, input int unsigned rd,
                      input int unsigned imm, input int unsigned adr,
                      input bit use_exp, input logic [31:0] expw);
    bit rdy;
    start    = st;
    finish   = fin;
    in_valid = v;
    in_mnem  = 4'(m);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_imm   = 16'(imm);
    in_adr   = 26'(adr);
    @(negedge clk);
    rdy = (m_state == 1) && (m_cnt < CAP);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    chk("busy", {31'b0, busy}, {31'b0, m_state == 1});
    chk("done", {31'b0, done}, {31'b0, m_state == 2});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("count", {29'b0, count}, m_cnt);
    if (v && rdy) begin
      if (m <= 8) begin
        sbq.push_back('{cyc + 1, m_ptr, use_exp ? expw : ref_enc(m, rs, rt, rd, imm, adr)});
        m_ptr = (m_ptr + 1) % CAP;
        m_cnt++;
      end else begin
        m_err = 1;
      end
    end
    if (m_state == 0 && st) begin
      m_state = 1; m_ptr = 0; m_cnt = 0; m_err = 0;
    end else if (m_state == 1 && fin) begin
      m_state = 2;
    end else if (m_state == 2) begin
      m_state = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0; finish = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle(input bit st, input bit fin);
    tick(0, st, fin, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic op(input int unsigned m, input int unsigned rs, input int unsigned rt,
                    input int unsigned rd, input int unsigned imm, input int unsigned adr,
                    input logic [31:0] expw, input bit fin);
    tick(1, 0, fin, m, rs, rt, rd, imm, adr, 1, expw);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_imem_we"}, {31'b0, imem_we}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
    chk({tag, "_imem_addr"}, {30'b0, imem_addr}, 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_count"}, {29'b0, count}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_adr = '0;
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Session 1: single add, finish outside LOAD ignored first.
    idle(0, 1);
    idle(1, 0);
    op(0, 1, 2, 3, 0, 0, 32'h0022_1820, 0);
    idle(0, 0);
    idle(0, 1);
    idle(0, 0);
    idle(0, 0);

    // Session 2: back-to-back I-types, fill to capacity, extra op refused.
    idle(1, 0);
    op(4, 0, 1, 0, 5, 0, 32'h2001_0005, 0);
    op(5, 1, 5, 0, 4, 0, 32'h8C25_0004, 0);
    op(6, 2, 5, 0, 8, 0, 32'hAC45_0008, 0);
    tick(1, 1, 0, 7, 1, 2, 0, 16'hFFFF, 0, 1, 32'h1022_FFFF);  // start while LOAD ignored
    op(8, 0, 0, 0, 0, 26'h40, 32'h0800_0040, 0);                // full: not accepted
    idle(0, 0);
    idle(0, 1);
    idle(0, 0);
    idle(0, 0);

    // Session 3: illegal mnemonic between ops; finish coincident with a transfer.
    idle(1, 0);
    op(7, 1, 2, 0, 16'hFFFF, 0, 32'h1022_FFFF, 0);
    op(12, 3, 4, 5, 6, 7, 32'h0, 0);
    op(8, 0, 0, 0, 0, 26'h40, 32'h0800_0040, 1);
    idle(0, 0);
    idle(0, 0);

    // Randomized sessions against the reference model.
    for (int s = 0; s < 8; s++) begin
      idle(1, 0);
      for (int k = 0; k < 10; k++) begin
        int unsigned m;
        m = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, k == 9, m,
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 65535), $urandom & 32'h03FF_FFFF, 0, '0);
      end
      idle(0, 0);
      idle(0, 0);
    end

    // Asynchronous reset mid-session, then restart at BASE_ADDR.
    idle(1, 0);
    op(0, 4, 5, 6, 0, 0, ref_enc(0, 4, 5, 6, 0, 0), 0);
    op(1, 7, 8, 9, 0, 0, ref_enc(1, 7, 8, 9, 0, 0), 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sbq.delete();
    m_state = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1, 0);
    op(2, 1, 2, 3, 0, 0, 32'h0022_1822, 0);
    idle(0, 1);
    idle(0, 0);
    idle(0, 0);

    chk("sb_drain", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
